// File: rtl/pdm_pkg.sv
//------------------------------------------------------------------------------
// pdm_pkg
//   Shared definitions for the PDM playback modulator:
//     state_t   - modulator control states (IDLE / PRIME / RUN)
//     FS        - full-scale magnitude for the default 16-bit sample width
//     fs_value  - full-scale magnitude 2^(w-1) for an arbitrary sample width
//     sat_acc   - symmetric saturation of a wide sum to an acc_w-bit signed range
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Width of the scratch arithmetic used inside the modulator datapath. Wide
    // enough that integrator + input + feedback can never overflow before the
    // clamp is applied, for any sensible accumulator width.
    localparam int unsigned CALC_WIDTH = 64;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    // Feedback magnitude: the DAC level that a 1 (or 0) on pdm_data represents.
    function automatic logic signed [CALC_WIDTH-1:0] fs_value(input int unsigned w);
        return 64'sd1 <<< (w - 1);
    endfunction

    localparam logic signed [CALC_WIDTH-1:0] FS = fs_value(DEFAULT_DATA_WIDTH);

    // Clamp to +/-(2^(acc_w-1)-1). The range is kept symmetric so the
    // integrators behave identically for positive and negative overload.
    function automatic logic signed [CALC_WIDTH-1:0] sat_acc(
        input logic signed [CALC_WIDTH-1:0] v,
        input int unsigned                  acc_w
    );
        logic signed [CALC_WIDTH-1:0] lim;
        lim = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction

endpackage : pdm_pkg

// File: rtl/pdm_clk_gen.sv
//------------------------------------------------------------------------------
// pdm_clk_gen
//   Divides clk down to the PDM bit clock and produces the one-cycle bit tick
//   that advances the modulator.
// Ports
//   clk       in   system clock
//   rst_n     in   async active-low reset
//   run       in   1 = count; 0 = hold divider at 0 and keep pdm_clk low
//   pdm_clk   out  bit clock, high for the first DIV/2 counts of each period
//   bit_tick  out  1-clk pulse on the last high count; the registered data
//                  update it triggers lands on the pdm_clk falling edge
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic pdm_clk,
    output logic bit_tick
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] HALF_CNT = DIV_W'(DIV / 2);
    localparam logic [DIV_W-1:0] TICK_CNT = DIV_W'(DIV / 2 - 1);

    logic [DIV_W-1:0] div_cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values of the others regardless of
    // statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!run) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST_CNT) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Decoded from flops only; gating with run keeps the output low through
    // the single IDLE cycle in which div_cnt has not yet been cleared.
    assign pdm_clk  = run && (div_cnt < HALF_CNT);
    assign bit_tick = run && (div_cnt == TICK_CNT);

endmodule : pdm_clk_gen

// File: rtl/pdm_modulator.sv
//------------------------------------------------------------------------------
// pdm_modulator
//   Converts signed PCM samples, delivered over a valid/ready handshake, into
//   a 1-bit PDM stream using a 2nd-order sigma-delta loop. Generates its own
//   pdm_clk so it can drive a PDM DAC/amplifier or loop back into a capture
//   chain.
// Ports
//   clk        in   system clock
//   rst_n      in   async active-low reset
//   enable     in   run modulator; low returns to IDLE and flushes everything
//   in_valid   in   PCM sample valid
//   in_ready   out  a sample can be accepted (running and buffer empty)
//   in_data    in   signed PCM sample, DATA_WIDTH bits
//   pdm_clk    out  PDM bit clock, 50% duty, period DIV clk
//   pdm_data   out  PDM bit, changes on the pdm_clk falling edge
//   underrun   out  1-clk pulse when an OSR boundary in RUN finds no sample
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIV        = 4,   // even, >= 2
    parameter int unsigned OSR        = 64,  // >= 2
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  pdm_clk,
    output logic                  pdm_data,
    output logic                  underrun
);

    localparam int unsigned OSR_W = $clog2(OSR);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);
    localparam logic signed [CALC_WIDTH-1:0] FB = fs_value(DATA_WIDTH);

    state_t state;

    logic                          bit_tick;
    logic                          run;
    logic [OSR_W-1:0]              osr_cnt;
    logic [OSR_W-1:0]              osr_next;
    logic                          boundary;
    logic                          accept;

    logic [DATA_WIDTH-1:0]         next_buf;
    logic                          next_full;
    logic signed [DATA_WIDTH-1:0]  cur_sample;

    logic signed [ACC_WIDTH-1:0]   i1;
    logic signed [ACC_WIDTH-1:0]   i2;
    logic signed [ACC_WIDTH-1:0]   i1_next;
    logic signed [ACC_WIDTH-1:0]   i2_next;
    logic                          mod_bit;

    logic signed [CALC_WIDTH-1:0]  x_term;
    logic signed [CALC_WIDTH-1:0]  fb_term;
    logic signed [CALC_WIDTH-1:0]  i1_sum;
    logic signed [CALC_WIDTH-1:0]  i2_sum;

    //--------------------------------------------------------------------------
    // Bit clock
    //--------------------------------------------------------------------------
    assign run = (state != IDLE);

    pdm_clk_gen #(
        .DIV (DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .pdm_clk  (pdm_clk),
        .bit_tick (bit_tick)
    );

    assign osr_next = (osr_cnt == OSR_LAST) ? '0 : osr_cnt + 1'b1;
    assign boundary = bit_tick && (osr_cnt == OSR_LAST);

    //--------------------------------------------------------------------------
    // Input handshake: single-entry skid buffer in front of cur_sample
    //--------------------------------------------------------------------------
    assign in_ready = run && !next_full;
    assign accept   = in_valid && in_ready;

    //--------------------------------------------------------------------------
    // Modulator datapath (evaluated every cycle, committed on bit_tick in RUN)
    //--------------------------------------------------------------------------
    // NOTE: every signal assigned in this always_comb receives a value on every
    // path before it is used, so no latch can be inferred.
    always_comb begin
        // Halve the input: a 2nd-order loop driven near full scale overloads.
        x_term  = CALC_WIDTH'(cur_sample) >>> 1;
        fb_term = pdm_data ? FB : -FB;
        i1_sum  = CALC_WIDTH'(i1) + x_term - fb_term;
        i1_next = ACC_WIDTH'(sat_acc(i1_sum, ACC_WIDTH));
        i2_sum  = CALC_WIDTH'(i2) + CALC_WIDTH'(i1_next) - fb_term;
        i2_next = ACC_WIDTH'(sat_acc(i2_sum, ACC_WIDTH));
        mod_bit = !i2_next[ACC_WIDTH-1];
    end

    //--------------------------------------------------------------------------
    // Control, buffering and output register
    //--------------------------------------------------------------------------
    // NOTE: the sample buffers are plain registers rather than a memory, so
    // they are reset with everything else and a restart never replays stale
    // data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            osr_cnt    <= '0;
            next_buf   <= '0;
            next_full  <= 1'b0;
            cur_sample <= '0;
            i1         <= '0;
            i2         <= '0;
            pdm_data   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (run && !enable) begin
                // Disable wins over everything, wherever we are in a sample.
                state      <= IDLE;
                osr_cnt    <= '0;
                next_buf   <= '0;
                next_full  <= 1'b0;
                cur_sample <= '0;
                i1         <= '0;
                i2         <= '0;
                pdm_data   <= 1'b0;
            end else begin
                // accept needs next_full=0 and the boundary load needs
                // next_full=1, so the two updates below never collide. An
                // accept in a boundary cycle is held for the next boundary.
                if (accept) begin
                    next_buf  <= in_data;
                    next_full <= 1'b1;
                end

                unique case (state)
                    IDLE: begin
                        if (enable) state <= PRIME;
                    end

                    PRIME: begin
                        if (bit_tick) begin
                            osr_cnt  <= osr_next;
                            // Alternating bits encode the zero level.
                            pdm_data <= !pdm_data;
                            if (boundary && next_full) begin
                                cur_sample <= next_buf;
                                next_full  <= 1'b0;
                                state      <= RUN;
                            end
                        end
                    end

                    RUN: begin
                        if (bit_tick) begin
                            osr_cnt  <= osr_next;
                            i1       <= i1_next;
                            i2       <= i2_next;
                            pdm_data <= mod_bit;
                            if (boundary) begin
                                if (next_full) begin
                                    cur_sample <= next_buf;
                                    next_full  <= 1'b0;
                                end else begin
                                    // Keep playing the previous sample.
                                    underrun <= 1'b1;
                                end
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : pdm_modulator

// File: tb/tb_pdm_modulator.sv
//------------------------------------------------------------------------------
// tb_pdm_modulator
//   Self-checking bench for pdm_modulator with DIV=4, OSR=64, DATA_WIDTH=16.
//   Covers reset, the PRIME idle pattern, output density for several DC
//   levels, handshake stalling and ordering, underrun pulses and disable /
//   re-enable mid-sample.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pdm_modulator;

    localparam int DW  = 16;
    localparam int DIV = 4;
    localparam int OSR = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          pdm_clk;
    logic          pdm_data;
    logic          underrun;

    pdm_modulator #(
        .DATA_WIDTH (DW),
        .DIV        (DIV),
        .OSR        (OSR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .pdm_clk  (pdm_clk),
        .pdm_data (pdm_data),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pdm_clk"},  32'(pdm_clk),  0);
        check({tag, " pdm_data"}, 32'(pdm_data), 0);
        check({tag, " in_ready"}, 32'(in_ready), 0);
        check({tag, " underrun"}, 32'(underrun), 0);
    endtask

    // PRIME start-up pattern, one entry per clk after enable is seen.
    typedef struct {
        logic clk_e;
        logic data_e;
    } prime_vec_t;

    prime_vec_t prime_tbl[8];

    // DC levels and their expected ones count per 256 PDM bits.
    typedef struct {
        string         name;
        logic [DW-1:0] sample;
        int            ones;
        int            tol;
    } dens_vec_t;

    dens_vec_t dens_tbl[4];

    // Call with enable just raised at a negedge from a settled IDLE state.
    task automatic check_prime(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("%s prime[%0d] pdm_clk", tag, i),  32'(pdm_clk),  32'(prime_tbl[i].clk_e));
            check($sformatf("%s prime[%0d] pdm_data", tag, i), 32'(pdm_data), 32'(prime_tbl[i].data_e));
            if (i == 0) begin
                check({tag, " prime in_ready"}, 32'(in_ready), 1);
                check({tag, " prime underrun"}, 32'(underrun), 0);
            end
        end
    endtask

    task automatic restart();
        enable   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Observe 1024 clk = 256 PDM bits; pdm_data is sampled at each pdm_clk rise.
    task automatic measure(output int ones, output int ur_cnt, output int ur_wide);
        logic prev_clk;
        logic prev_ur;
        ones     = 0;
        ur_cnt   = 0;
        ur_wide  = 0;
        prev_clk = pdm_clk;
        prev_ur  = underrun;
        for (int i = 0; i < 256 * DIV; i++) begin
            @(negedge clk);
            if (pdm_clk && !prev_clk && pdm_data) ones++;
            if (underrun) ur_cnt++;
            if (underrun && prev_ur) ur_wide++;
            prev_clk = pdm_clk;
            prev_ur  = underrun;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        int ur_cnt;
        int ur_wide;
        int t;
        bit found;

        prime_tbl[0] = '{1'b1, 1'b0};
        prime_tbl[1] = '{1'b1, 1'b0};
        prime_tbl[2] = '{1'b0, 1'b1};
        prime_tbl[3] = '{1'b0, 1'b1};
        prime_tbl[4] = '{1'b1, 1'b1};
        prime_tbl[5] = '{1'b1, 1'b1};
        prime_tbl[6] = '{1'b0, 1'b0};
        prime_tbl[7] = '{1'b0, 1'b0};

        dens_tbl[0] = '{"dc_zero",     16'h0000, 128, 2};
        dens_tbl[1] = '{"dc_plus_half",16'h4000, 160, 2};
        dens_tbl[2] = '{"dc_minus_half",16'hC000, 96, 2};
        dens_tbl[3] = '{"dc_neg_full", 16'h8000,  64, 3};

        // ---- Reset ---------------------------------------------------------
        rst_n    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("post_reset");

        // ---- PRIME with no samples ----------------------------------------
        enable = 1'b1;
        check_prime("first");
        measure(ones, ur_cnt, ur_wide);
        check("prime ones per 256", 32'(ones), 128);
        check("prime underrun count", 32'(ur_cnt), 0);
        check("prime in_ready", 32'(in_ready), 1);

        // ---- DC density table ---------------------------------------------
        for (int v = 0; v < 4; v++) begin
            restart();
            in_data  = dens_tbl[v].sample;
            in_valid = 1'b1;
            enable   = 1'b1;
            repeat (128 * DIV) @(negedge clk);
            measure(ones, ur_cnt, ur_wide);
            check_range({dens_tbl[v].name, " ones"}, ones,
                        dens_tbl[v].ones - dens_tbl[v].tol,
                        dens_tbl[v].ones + dens_tbl[v].tol);
            check({dens_tbl[v].name, " underrun"}, 32'(ur_cnt), 0);
        end

        // ---- Back-to-back samples: stall, ordering, no loss ---------------
        restart();
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h4000;
        @(negedge clk);                         // first PRIME cycle
        check("b2b first in_ready", 32'(in_ready), 1);
        @(negedge clk);                         // A accepted at previous edge
        check("b2b stall in_ready", 32'(in_ready), 0);
        in_data = 16'hC000;
        t = 1;
        while (in_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("b2b ready returns at cycle", 32'(t), 254);
        @(negedge clk);                         // B accepted at previous edge
        t++;
        check("b2b second held in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        while (underrun !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("b2b first underrun at cycle", 32'(t), 766);

        // ---- Feed stops in RUN --------------------------------------------
        restart();
        in_data  = 16'h4000;
        in_valid = 1'b1;
        enable   = 1'b1;
        repeat (128 * DIV) @(negedge clk);
        in_valid = 1'b0;
        repeat (128 * DIV) @(negedge clk);
        measure(ones, ur_cnt, ur_wide);
        check_range("starved ones", ones, 158, 162);
        check("starved underrun pulses", 32'(ur_cnt), 4);
        check("starved underrun wide", 32'(ur_wide), 0);

        // ---- Sustained negative full scale, disable mid-sample ------------
        restart();
        in_data  = 16'h8000;
        in_valid = 1'b1;
        enable   = 1'b1;
        repeat (200 * DIV) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (pdm_clk && pdm_data) found = 1'b1;
        end
        check("disable found high bit", 32'(found), 1);
        enable   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_all_zero("disabled");
        enable = 1'b1;
        check_prime("reenable");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pdm_modulator
